mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Data-memory side of the CPU datapath: accepts one load/store request from the execute stage and runs it on the Avalon-MM data bus.
- Store path narrows and places register data:
  - truncates to byte or halfword;
  - replicates across lanes;
  - generates byteenable.
- Load path extracts the addressed lane and sign- or zero-extends it to 32 bits.
- Multi-cycle; stalls the core via busy until done.

Parameters:
- MAX_WAIT, 0, waitrequest timeout in cycles. 0 means wait forever. N>0 means abort with fault after N consecutive stalled cycles.
- ADDR_W, 32, byte address width.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- start  input  1  request strobe; sampled only when busy=0
- opcode  input  6  MIPS opcode of the memory instruction
- addr  input  ADDR_W  effective byte address
- store_data  input  32  rt register value
- busy  output  1  request in flight
- done  output  1  one-cycle completion pulse
- fault  output  1  valid with done: misaligned, unsupported opcode, or timeout
- load_data  output  32  extended load result; valid from done until next accepted start
- avm_address  output  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- avm_read  output  1  Avalon read
- avm_write  output  1  Avalon write
- avm_writedata  output  32  lane-placed store data
- avm_byteenable  output  4  active lanes
- avm_readdata  input  32  read data, valid when avm_read=1 and avm_waitrequest=0
- avm_waitrequest  input  1  slave stall

Behaviour:
- Reset (asynchronous, immediate) clears all outputs to 0 and puts the FSM in IDLE. A reset mid-transaction drops avm_read/avm_write the same instant; no done is produced.
- Byte lanes are little-endian: lane k = bits [8k+7:8k], selected by k = addr[1:0].
- FSM states IDLE, CHECK, BUS, DONE.
  - IDLE: start=1 latches opcode, addr and store_data; moves to CHECK; busy rises the next cycle.
  - CHECK (one cycle) classifies the request:
    - unsupported opcode, halfword access with addr[0]=1, or word access with addr[1:0]≠0 sets fault and goes to DONE with no bus cycle;
    - otherwise drives the bus signals and goes to BUS.
  - BUS: avm_read or avm_write, address, writedata and byteenable are held stable while avm_waitrequest=1.
    - On the first cycle with waitrequest=0: capture readdata for loads, deassert read/write next cycle, go to DONE.
    - Timeout: a stall counter increments on each stalled cycle. If MAX_WAIT>0 and the counter reaches MAX_WAIT, deassert the bus, set fault and go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- start while busy=1 is ignored. start in the DONE cycle is also ignored; the core issues it after done.
- Store encoding:
  - SB: writedata={4{d[7:0]}}, byteenable=4'b0001<<k.
  - SH: writedata={2{d[15:0]}}, byteenable=k[1]?4'b1100:4'b0011.
  - SW: writedata=d, byteenable=4'b1111.
- Load encoding (byteenable mirrors the store rules for the access size):
  - LB/LBU: lane k, sign-/zero-extended from bit 7.
  - LH/LHU: halfword k[1], sign-/zero-extended from bit 15.
  - LW: full word.
- load_data is registered. It is 0 after a faulted or store request.
- Latency: no-wait store is start@0, CHECK@1, write@2, done@3. Each wait cycle adds 1.

Decomposition:
- Shared package constants: OPCODE_LB=6'h20, OPCODE_LH=6'h21, OPCODE_LW=6'h23, OPCODE_LBU=6'h24, OPCODE_LHU=6'h25, OPCODE_SB=6'h28, OPCODE_SH=6'h29, OPCODE_SW=6'h2B.
- Shared package typedef: enum mem_state_t {IDLE,CHECK,BUS,DONE}.
- One combinational sub-module, load_extend, takes opcode, addr[1:0] and readdata and returns the extended word. It is reusable by the LWL/LWR work.

Test Plan:
- Store: SB addr=0x1003, data=0xAABBCCDD, no wait -> avm_address=0x1000, writedata=0xDDDDDDDD, byteenable=4'b1000, write high 1 cycle, done@3, fault=0.
- Load sign: LB addr=0x2001, readdata=0x00008000 -> load_data=0xFFFFFF80. Same access with LBU -> 0x00000080. LH addr=0x2002, readdata=0x80010000 -> 0xFFFF8001.
- Wait states: SW with waitrequest high 3 cycles -> bus signals stable throughout, done@6.
- Fault: LW addr=0x3002 -> no avm_read ever, done@2 with fault=1. Same with MAX_WAIT=4 and waitrequest stuck high -> abort after 4 stalled cycles, fault=1.
- Reset/overlap: assert reset during BUS -> avm_write=0 immediately, busy=0, no done. Second start while busy -> ignored, exactly one bus cycle.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared opcode constants, FSM state type and access-size helpers for the
// data-memory access unit.
package mem_access_unit_pkg;

    localparam logic [5:0] OPCODE_LB  = 6'h20;
    localparam logic [5:0] OPCODE_LH  = 6'h21;
    localparam logic [5:0] OPCODE_LW  = 6'h23;
    localparam logic [5:0] OPCODE_LBU = 6'h24;
    localparam logic [5:0] OPCODE_LHU = 6'h25;
    localparam logic [5:0] OPCODE_SB  = 6'h28;
    localparam logic [5:0] OPCODE_SH  = 6'h29;
    localparam logic [5:0] OPCODE_SW  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        BUS   = 2'd2,
        DONE  = 2'd3
    } mem_state_t;

    typedef enum logic [1:0] {
        SIZE_NONE = 2'd0,
        SIZE_BYTE = 2'd1,
        SIZE_HALF = 2'd2,
        SIZE_WORD = 2'd3
    } mem_size_t;

    // Access width implied by a memory opcode; SIZE_NONE marks anything unsupported.
    function automatic mem_size_t access_size(input logic [5:0] op);
        mem_size_t size;
        case (op)
            OPCODE_LB, OPCODE_LBU, OPCODE_SB: size = SIZE_BYTE;
            OPCODE_LH, OPCODE_LHU, OPCODE_SH: size = SIZE_HALF;
            OPCODE_LW, OPCODE_SW:             size = SIZE_WORD;
            default:                          size = SIZE_NONE;
        endcase
        return size;
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OPCODE_SB) || (op == OPCODE_SH) || (op == OPCODE_SW);
    endfunction

    // Halfwords must sit on an even address, words on a multiple of four.
    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] lane);
        logic bad;
        case (size)
            SIZE_HALF: bad = lane[0];
            SIZE_WORD: bad = (lane != 2'b00);
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Byte lanes touched by an access of the given size at lane offset k.
    function automatic logic [3:0] lane_enable(input mem_size_t size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << lane;
            SIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the narrowed store value across every lane; byteenable picks the live one.
    function automatic logic [31:0] place_store(input mem_size_t size, input logic [31:0] d);
        logic [31:0] wd;
        case (size)
            SIZE_BYTE: wd = {4{d[7:0]}};
            SIZE_HALF: wd = {2{d[15:0]}};
            SIZE_WORD: wd = d;
            default:   wd = 32'h0000_0000;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational load alignment: picks the addressed byte/halfword out of the
// bus word and sign- or zero-extends it to 32 bits.
module load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  lane,
    input  logic [31:0] readdata,
    output logic [31:0] ext
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection and extension according to the load opcode.
    always_comb begin
        byte_s = readdata[{lane, 3'b000} +: 8];
        half_s = lane[1] ? readdata[31:16] : readdata[15:0];
        case (opcode)
            OPCODE_LB:  ext = {{24{byte_s[7]}}, byte_s};
            OPCODE_LBU: ext = {24'h00_0000, byte_s};
            OPCODE_LH:  ext = {{16{half_s[15]}}, half_s};
            OPCODE_LHU: ext = {16'h0000, half_s};
            OPCODE_LW:  ext = readdata;
            default:    ext = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access unit: takes one load/store from execute, classifies it,
// runs it on the Avalon-MM data bus and reports done/fault with the loaded value.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 0,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [5:0]        opcode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [31:0]       load_data,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
);

    // Stall count at which the abort fires (only meaningful when MAX_WAIT is non-zero).
    localparam logic [31:0] STALL_LIMIT = 32'(MAX_WAIT) - 32'd1;

    mem_state_t        state_r, state_s;
    logic [5:0]        opcode_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       store_data_r;
    logic [31:0]       stall_cnt_r, stall_cnt_s;
    logic              latch_s;
    logic              busy_s, done_s, fault_s;
    logic [31:0]       load_data_s;
    logic              read_s, write_s;
    logic [ADDR_W-1:0] address_s;
    logic [31:0]       wdata_s;
    logic [3:0]        be_s;
    logic [31:0]       load_ext_s;
    mem_size_t         size_s;
    logic              store_s;

    assign size_s  = access_size(opcode_r);
    assign store_s = is_store(opcode_r);

    load_extend u_load_extend (
        .opcode   (opcode_r),
        .lane     (addr_r[1:0]),
        .readdata (avm_readdata),
        .ext      (load_ext_s)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic and next values for every registered output.
    always_comb begin
        state_s     = state_r;
        latch_s     = 1'b0;
        stall_cnt_s = stall_cnt_r;
        busy_s      = busy;
        done_s      = 1'b0;
        fault_s     = 1'b0;
        load_data_s = load_data;
        read_s      = avm_read;
        write_s     = avm_write;
        address_s   = avm_address;
        wdata_s     = avm_writedata;
        be_s        = avm_byteenable;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = CHECK;
                    latch_s = 1'b1;
                    busy_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            CHECK: begin
                if ((size_s == SIZE_NONE) || is_misaligned(size_s, addr_r[1:0])) begin
                    state_s     = DONE;
                    busy_s      = 1'b0;
                    done_s      = 1'b1;
                    fault_s     = 1'b1;
                    load_data_s = 32'h0000_0000;
                end else begin
                    state_s     = BUS;
                    read_s      = ~store_s;
                    write_s     = store_s;
                    address_s   = {addr_r[ADDR_W-1:2], 2'b00};
                    wdata_s     = store_s ? place_store(size_s, store_data_r) : 32'h0000_0000;
                    be_s        = lane_enable(size_s, addr_r[1:0]);
                    stall_cnt_s = 32'd0;
                end
            end
            BUS: begin
                if (!avm_waitrequest) begin
                    state_s     = DONE;
                    read_s      = 1'b0;
                    write_s     = 1'b0;
                    busy_s      = 1'b0;
                    done_s      = 1'b1;
                    load_data_s = store_s ? 32'h0000_0000 : load_ext_s;
                end else if ((MAX_WAIT != 0) && (stall_cnt_r == STALL_LIMIT)) begin
                    state_s     = DONE;
                    read_s      = 1'b0;
                    write_s     = 1'b0;
                    busy_s      = 1'b0;
                    done_s      = 1'b1;
                    fault_s     = 1'b1;
                    load_data_s = 32'h0000_0000;
                end else begin
                    stall_cnt_s = stall_cnt_r + 32'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
                read_s  = 1'b0;
                write_s = 1'b0;
            end
        endcase
    end

    // Request latches, stall counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opcode_r       <= 6'd0;
            addr_r         <= '0;
            store_data_r   <= 32'h0000_0000;
            stall_cnt_r    <= 32'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            fault          <= 1'b0;
            load_data      <= 32'h0000_0000;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= 32'h0000_0000;
            avm_byteenable <= 4'b0000;
        end else begin
            if (latch_s) begin
                opcode_r     <= opcode;
                addr_r       <= addr;
                store_data_r <= store_data;
            end else begin
                opcode_r     <= opcode_r;
                addr_r       <= addr_r;
                store_data_r <= store_data_r;
            end
            stall_cnt_r    <= stall_cnt_s;
            busy           <= busy_s;
            done           <= done_s;
            fault          <= fault_s;
            load_data      <= load_data_s;
            avm_address    <= address_s;
            avm_read       <= read_s;
            avm_write      <= write_s;
            avm_writedata  <= wdata_s;
            avm_byteenable <= be_s;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// requests compared against an arithmetic reference model.
module tb_mem_access_unit;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  opcode;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy, done, fault;
    logic [31:0] load_data;
    logic [31:0] avm_address;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.MAX_WAIT(MAXW), .ADDR_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .opcode          (opcode),
        .addr            (addr),
        .store_data      (store_data),
        .busy            (busy),
        .done            (done),
        .fault           (fault),
        .load_data       (load_data),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int op_bytes(input logic [5:0] op);
        case (op)
            6'h20, 6'h24, 6'h28: return 1;
            6'h21, 6'h25, 6'h29: return 2;
            6'h23, 6'h2B:        return 4;
            default:             return 0;
        endcase
    endfunction

    function automatic bit op_store(input logic [5:0] op);
        return (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
    endfunction

    function automatic bit op_fault(input logic [5:0] op, input logic [31:0] a);
        int n;
        n = op_bytes(op);
        return (n == 0) || ((a % n) != 0);
    endfunction

    function automatic logic [3:0] model_be(input int n, input logic [31:0] a);
        int m;
        m = ((1 << n) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wd(input int n, input logic [31:0] d);
        if (n == 1) return (d & 32'h0000_00FF) * 32'h0101_0101;
        else if (n == 2) return (d & 32'h0000_FFFF) * 32'h0001_0001;
        else return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] a,
                                               input logic [31:0] rd);
        int n;
        logic [63:0] v, full;
        n = op_bytes(op);
        if (n == 4) return rd;
        v    = {32'h0, rd >> (8 * (a % 4))};
        full = 64'd1 << (8 * n);
        v    = v % full;
        if (((op == 6'h20) || (op == 6'h21)) && (v >= full / 2)) v = v - full;
        return v[31:0];
    endfunction

    // ---------------- one request, fully checked ----------------
    task automatic do_req(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] rd, input int waits,
                          input bit hold);
        int n, bus_cnt, done_cyc, exp_done, exp_bus;
        bit flt, st, tmo;
        logic [31:0] exp_ld;
        n   = op_bytes(op);
        flt = op_fault(op, a);
        st  = op_store(op);
        tmo = !flt && (waits >= MAXW);
        exp_done = flt ? 2 : (tmo ? 2 + MAXW : 3 + waits);
        exp_bus  = flt ? 0 : (tmo ? MAXW : waits + 1);
        exp_ld   = (flt || tmo || st) ? 32'h0 : model_load(op, a, rd);

        @(negedge clk);
        opcode = op; addr = a; store_data = d; avm_readdata = rd;
        avm_waitrequest = 1'b0; start = 1'b1;
        bus_cnt = 0; done_cyc = -1;
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (c == 1) check({tag, " busy_rise"}, {31'h0, busy}, 32'h1);
            if (avm_read || avm_write) begin
                bus_cnt++;
                check({tag, " address"}, avm_address, a & 32'hFFFF_FFFC);
                check({tag, " read"}, {31'h0, avm_read}, {31'h0, !st});
                check({tag, " write"}, {31'h0, avm_write}, {31'h0, st});
                check({tag, " byteenable"}, {28'h0, avm_byteenable}, {28'h0, model_be(n, a)});
                if (st) check({tag, " writedata"}, avm_writedata, model_wd(n, d));
                avm_waitrequest = (bus_cnt <= waits);
            end else begin
                avm_waitrequest = 1'b0;
            end
            if (done) begin
                done_cyc = c;
                check({tag, " fault"}, {31'h0, fault}, {31'h0, flt || tmo});
                check({tag, " load_data"}, load_data, exp_ld);
                check({tag, " busy_at_done"}, {31'h0, busy}, 32'h0);
            end
        end
        check({tag, " done_cycle"}, done_cyc, exp_done);
        check({tag, " bus_cycles"}, bus_cnt, exp_bus);
        @(negedge clk);
        start = 1'b0;
        avm_waitrequest = 1'b0;
        check({tag, " done_pulse"}, {31'h0, done}, 32'h0);
        check({tag, " idle_busy"}, {31'h0, busy}, 32'h0);
    endtask

    logic [5:0] ops [11] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B,
                             6'h22, 6'h2A, 6'h0F};

    initial begin
        int done_seen;
        logic [5:0]  rop;
        logic [31:0] ra;
        int rn, rw;

        reset = 1'b1; start = 1'b0; opcode = 6'h0; addr = 32'h0; store_data = 32'h0;
        avm_readdata = 32'h0; avm_waitrequest = 1'b0;
        #12;
        check("reset busy", {31'h0, busy}, 32'h0);
        check("reset done", {31'h0, done}, 32'h0);
        check("reset bus", {30'h0, avm_read, avm_write}, 32'h0);
        check("reset load_data", load_data, 32'h0);
        check("reset byteenable", {28'h0, avm_byteenable}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Directed cases
        do_req("sb_1003",   6'h28, 32'h0000_1003, 32'hAABB_CCDD, 32'h0, 0, 1'b0);
        do_req("lb_sign",   6'h20, 32'h0000_2001, 32'h0, 32'h0000_8000, 0, 1'b0);
        do_req("lbu_zero",  6'h24, 32'h0000_2001, 32'h0, 32'h0000_8000, 0, 1'b0);
        do_req("lh_sign",   6'h21, 32'h0000_2002, 32'h0, 32'h8001_0000, 0, 1'b0);
        do_req("lhu_zero",  6'h25, 32'h0000_2002, 32'h0, 32'h8001_0000, 1, 1'b0);
        do_req("sh_hi",     6'h29, 32'h0000_4002, 32'h1234_5678, 32'h0, 0, 1'b0);
        do_req("sw_wait3",  6'h2B, 32'h0000_5000, 32'hCAFE_F00D, 32'h0, 3, 1'b0);
        do_req("lw_misal",  6'h23, 32'h0000_3002, 32'h0, 32'h1111_1111, 0, 1'b0);
        do_req("lh_odd",    6'h21, 32'h0000_3001, 32'h0, 32'h1111_1111, 0, 1'b0);
        do_req("bad_op",    6'h22, 32'h0000_3000, 32'h0, 32'h1111_1111, 0, 1'b0);
        do_req("lw_tmo",    6'h23, 32'h0000_3000, 32'h0, 32'h2222_2222, 10, 1'b0);
        do_req("lw_wait3",  6'h23, 32'h0000_6004, 32'h0, 32'hDEAD_BEEF, 3, 1'b0);
        do_req("sw_overlap", 6'h2B, 32'h0000_7000, 32'h0BAD_0BAD, 32'h0, 1, 1'b1);

        // Reset during BUS: bus drops immediately and no done follows
        @(negedge clk);
        opcode = 6'h2B; addr = 32'h0000_8000; store_data = 32'h5555_AAAA; start = 1'b1;
        avm_waitrequest = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("rst_mid write_before", {31'h0, avm_write}, 32'h1);
        #1 reset = 1'b1;
        #1;
        check("rst_mid write", {31'h0, avm_write}, 32'h0);
        check("rst_mid busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done || avm_write || busy) done_seen++;
        end
        check("rst_mid no_done", done_seen, 0);

        // Randomized requests against the model
        for (int i = 0; i < 60; i++) begin
            rop = ops[$urandom_range(0, 10)];
            ra  = $urandom;
            rn  = op_bytes(rop);
            if (rn > 0 && $urandom_range(0, 3) != 0) ra = ra - (ra % rn);
            rw  = ($urandom_range(0, 9) == 0) ? 6 : $urandom_range(0, 3);
            do_req("rand", rop, ra, $urandom, $urandom, rw, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
